// File: rtl/vga_pkg.sv
// Shared types for the VGA timing sink.
//   state_e    : sequencer states (load mode / run frame / illegal mode)
//   mode_t     : one axis' timing mode, zero-extended to MODE_W bits
//   mode_legal : true when an axis mode can be scanned out
package vga_pkg;

    // Wide enough for any supported HW/VW; axis values are zero-extended.
    localparam int MODE_W = 16;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_BAD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [MODE_W-1:0] width;  // active positions
        logic [MODE_W-1:0] porch;  // first sync position
        logic [MODE_W-1:0] synch;  // first position after sync
        logic [MODE_W-1:0] raw;    // total positions
    } mode_t;

    // Active region must be non-empty and end before the sync pulse, the
    // sync pulse may be empty (porch == synch) but must fit inside raw.
    function automatic logic mode_legal(input mode_t m);
        return (m.width != '0) &&
               (m.width < m.porch) &&
               (m.porch <= m.synch) &&
               (m.synch <= m.raw) &&
               (m.raw >= MODE_W'(2));
    endfunction

endpackage

// File: rtl/vga_timing_sink_if.sv
// Pixel request/return channel between the timing sink and a pixel source.
//   o_rd       : sink -> source, request one pixel this clock
//   o_newline  : sink -> source, one-clock pulse on the last column of a line
//   o_newframe : sink -> source, one-clock pulse on the last column of a frame
//   i_pixel    : source -> sink, {R,G,B} word
//
// Handshake: there is no ready/back-pressure. The sink owns the pace; every
// clock on which o_rd is high the source must present the requested pixel on
// i_pixel during the following clock (it registers its read data), and the
// sink samples it at the end of that clock. i_pixel is don't-care otherwise.
interface vga_timing_sink_if #(
    parameter int BPC = 4
) ();
    logic             o_rd;
    logic             o_newline;
    logic             o_newframe;
    logic [3*BPC-1:0] i_pixel;

    modport master (output o_rd, output o_newline, output o_newframe, input i_pixel);
    modport slave  (input o_rd, input o_newline, input o_newframe, output i_pixel);
endinterface

// File: rtl/vga_axis_counter.sv
// One display axis: position counter, shadow copy of the axis mode, and the
// active/sync/last decode of the current position.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : capture width/porch/synch/raw into the shadow registers
//   run_i         : counter runs; when low the position is held at zero
//   en_i          : advance the position this clock (wraps at raw-1)
//   width_i..raw_i: live mode inputs, only looked at while load_i is high
//   active_o      : position < width
//   sync_o        : porch <= position < synch
//   last_o        : position == raw-1
module vga_axis_counter #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         run_i,
    input  logic         en_i,
    input  logic [W-1:0] width_i,
    input  logic [W-1:0] porch_i,
    input  logic [W-1:0] synch_i,
    input  logic [W-1:0] raw_i,
    output logic         active_o,
    output logic         sync_o,
    output logic         last_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] width_q, porch_q, synch_q, raw_q;
    logic [W-1:0] pos_q, pos_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            width_q <= '0;
            porch_q <= '0;
            synch_q <= '0;
            raw_q   <= '0;
            pos_q   <= '0;
        end else begin
            if (load_i) begin
                width_q <= width_i;
                porch_q <= porch_i;
                synch_q <= synch_i;
                raw_q   <= raw_i;
            end
            pos_q <= pos_d;
        end
    end

    always_comb begin
        pos_d = pos_q;
        if (!run_i) begin
            pos_d = '0;
        end else if (en_i) begin
            pos_d = last_o ? '0 : pos_q + ONE;
        end
    end

    assign last_o   = (pos_q == raw_q - ONE);
    assign active_o = (pos_q < width_q);
    assign sync_o   = (pos_q >= porch_q) && (pos_q < synch_q);

endmodule

// File: rtl/vga_timing_sink.sv
// Display-side VGA timing engine. Scans a runtime-programmable mode, issues
// pixel requests and line/frame pulses to a pixel source, and drives VGA
// sync and colour outputs aligned with the returned pixel data.
//   i_pixclk, i_reset_n   : pixel clock, async active-low reset
//   i_hm_* / i_vm_*       : horizontal / vertical mode, latched once per frame
//   pix_if (master)       : o_rd / o_newline / o_newframe out, i_pixel in
//   o_vga_hsync/vsync     : sync outputs, active level HSYNC_POL / VSYNC_POL
//   o_vga_red/green/blue  : colour, zero outside the active area
//   o_mode_err            : latched mode is illegal
//   o_dbg_state           : current sequencer state
//
// Pipeline: counters -> stage 1 (strobes, raw syncs) -> stage 2 (delay while
// the source fetches) -> stage 3 (RGB + syncs). RGB lands 2 clocks after o_rd.
module vga_timing_sink
    import vga_pkg::*;
#(
    parameter int BITS_PER_COLOR = 4,
    parameter int HW             = 12,
    parameter int VW             = 12,
    parameter bit HSYNC_POL      = 1'b0,
    parameter bit VSYNC_POL      = 1'b0
) (
    input  logic                      i_pixclk,
    input  logic                      i_reset_n,
    input  logic [HW-1:0]             i_hm_width,
    input  logic [HW-1:0]             i_hm_porch,
    input  logic [HW-1:0]             i_hm_synch,
    input  logic [HW-1:0]             i_hm_raw,
    input  logic [VW-1:0]             i_vm_height,
    input  logic [VW-1:0]             i_vm_porch,
    input  logic [VW-1:0]             i_vm_synch,
    input  logic [VW-1:0]             i_vm_raw,
    vga_timing_sink_if.master         pix_if,
    output logic                      o_vga_hsync,
    output logic                      o_vga_vsync,
    output logic [BITS_PER_COLOR-1:0] o_vga_red,
    output logic [BITS_PER_COLOR-1:0] o_vga_green,
    output logic [BITS_PER_COLOR-1:0] o_vga_blue,
    output logic                      o_mode_err,
    output state_e                    o_dbg_state
);

    localparam int BPC = BITS_PER_COLOR;
    localparam int PW  = 3 * BPC;

    state_e state_q, state_d;
    logic   load, run;
    logic   mode_err_q, mode_err_d;
    logic   live_legal;
    mode_t  h_live, v_live;

    logic h_active, h_sync, h_last;
    logic v_active, v_sync, v_last;

    // stage 1 / 2 / 3 registers
    logic          rd1_q, newline_q, newframe_q, hs1_q, vs1_q;
    logic          rd2_q, hs2_q, vs2_q;
    logic [PW-1:0] rgb_q, rgb_d;
    logic          hsync_q, vsync_q;

    assign h_live = '{width: MODE_W'(i_hm_width), porch: MODE_W'(i_hm_porch),
                      synch: MODE_W'(i_hm_synch), raw:   MODE_W'(i_hm_raw)};
    assign v_live = '{width: MODE_W'(i_vm_height), porch: MODE_W'(i_vm_porch),
                      synch: MODE_W'(i_vm_synch),  raw:   MODE_W'(i_vm_raw)};

    // Judged on the live inputs in the same clock they are latched, so the
    // shadow registers and the legality verdict always describe one mode.
    assign live_legal = mode_legal(h_live) && mode_legal(v_live);

    vga_axis_counter #(.W(HW)) u_h (
        .clk_i    (i_pixclk),
        .rst_ni   (i_reset_n),
        .load_i   (load),
        .run_i    (run),
        .en_i     (run),
        .width_i  (i_hm_width),
        .porch_i  (i_hm_porch),
        .synch_i  (i_hm_synch),
        .raw_i    (i_hm_raw),
        .active_o (h_active),
        .sync_o   (h_sync),
        .last_o   (h_last)
    );

    // The vertical axis steps only on the horizontal wrap.
    vga_axis_counter #(.W(VW)) u_v (
        .clk_i    (i_pixclk),
        .rst_ni   (i_reset_n),
        .load_i   (load),
        .run_i    (run),
        .en_i     (run && h_last),
        .width_i  (i_vm_height),
        .porch_i  (i_vm_porch),
        .synch_i  (i_vm_synch),
        .raw_i    (i_vm_raw),
        .active_o (v_active),
        .sync_o   (v_sync),
        .last_o   (v_last)
    );

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_LOAD;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_err_q <= mode_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_err_d = mode_err_q;
        load       = 1'b0;
        run        = 1'b0;
        case (state_q)
            S_LOAD: begin
                load       = 1'b1;
                mode_err_d = !live_legal;
                state_d    = live_legal ? S_RUN : S_BAD;
            end
            S_RUN: begin
                run = 1'b1;
                // Both axes wrapping together is the end of the frame.
                if (h_last && v_last) begin
                    state_d = S_LOAD;
                end
            end
            S_BAD: begin
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign rgb_d = rd2_q ? pix_if.i_pixel : '0;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd1_q      <= 1'b0;
            newline_q  <= 1'b0;
            newframe_q <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            rd2_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            rgb_q      <= '0;
            hsync_q    <= ~HSYNC_POL;
            vsync_q    <= ~VSYNC_POL;
        end else begin
            // Outside S_RUN every stage-1 term is forced low, which blanks
            // the load clock and the whole illegal-mode period.
            rd1_q      <= run && h_active && v_active;
            newline_q  <= run && h_last;
            newframe_q <= run && h_last && v_last;
            hs1_q      <= run && h_sync;
            vs1_q      <= run && v_sync;
            rd2_q      <= rd1_q;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
            rgb_q      <= rgb_d;
            hsync_q    <= hs2_q ? HSYNC_POL : ~HSYNC_POL;
            vsync_q    <= vs2_q ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign pix_if.o_rd       = rd1_q;
    assign pix_if.o_newline  = newline_q;
    assign pix_if.o_newframe = newframe_q;
    assign o_vga_red         = rgb_q[PW-1 -: BPC];
    assign o_vga_green       = rgb_q[2*BPC-1 -: BPC];
    assign o_vga_blue        = rgb_q[BPC-1:0];
    assign o_vga_hsync       = hsync_q;
    assign o_vga_vsync       = vsync_q;
    assign o_mode_err        = mode_err_q;
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_vga_timing_sink.sv
// Bench for vga_timing_sink: table of modes with hand-derived per-frame
// counts, hand sequences for the corner cases, and a frame-time reference
// model (position = frame clock index split by the line length) checked
// against every output on every clock.
module tb_vga_timing_sink;
    import vga_pkg::*;

    localparam int BPC = 4;
    localparam int PW  = 3 * BPC;
    localparam int PH_LOAD = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_BAD  = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- DUT ----------------
    logic [11:0]    hm_width, hm_porch, hm_synch, hm_raw;
    logic [11:0]    vm_height, vm_porch, vm_synch, vm_raw;
    logic           hsync, vsync, mode_err;
    logic [BPC-1:0] red, green, blue;
    state_e         dbg_state;

    vga_timing_sink_if #(.BPC(BPC)) pix_if ();

    vga_timing_sink #(
        .BITS_PER_COLOR(BPC), .HW(12), .VW(12),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .i_pixclk    (clk),
        .i_reset_n   (rst_n),
        .i_hm_width  (hm_width),
        .i_hm_porch  (hm_porch),
        .i_hm_synch  (hm_synch),
        .i_hm_raw    (hm_raw),
        .i_vm_height (vm_height),
        .i_vm_porch  (vm_porch),
        .i_vm_synch  (vm_synch),
        .i_vm_raw    (vm_raw),
        .pix_if      (pix_if.master),
        .o_vga_hsync (hsync),
        .o_vga_vsync (vsync),
        .o_vga_red   (red),
        .o_vga_green (green),
        .o_vga_blue  (blue),
        .o_mode_err  (mode_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- table ----------------
    typedef struct {
        int hw, hp, hs, hr;
        int vh, vp, vs, vr;
        int exp_rd, exp_nl, exp_period, exp_err;
    } vec_t;
    vec_t vecs[5];

    // ---------------- reference model ----------------
    typedef struct { bit rd, nl, nf, hs, vs; } s1_t;
    s1_t           s1q[$];   // stage-1 values of the last three clocks, newest last
    int            m_phase, m_t;
    int            m_hw, m_hp, m_hs, m_hr, m_vh, m_vp, m_vs, m_vr;
    bit            m_err;
    logic [PW-1:0] m_rgb;

    function automatic bit legal(int w, int p, int s, int r);
        return (w > 0) && (w < p) && (p <= s) && (s <= r) && (r >= 2);
    endfunction

    task automatic model_reset();
        s1_t z;
        z = '{default: 1'b0};
        m_phase = PH_LOAD;
        m_t     = 0;
        m_err   = 1'b0;
        m_rgb   = '0;
        s1q.delete();
        repeat (3) s1q.push_back(z);
    endtask

    task automatic model_step();
        s1_t s;
        int  h, v;
        s = '{default: 1'b0};
        if (m_phase == PH_RUN) begin
            h    = m_t % m_hr;
            v    = m_t / m_hr;
            s.rd = (h < m_hw) && (v < m_vh);
            s.nl = (h == m_hr - 1);
            s.nf = s.nl && (v == m_vr - 1);
            s.hs = (h >= m_hp) && (h < m_hs);
            s.vs = (v >= m_vp) && (v < m_vs);
        end
        s1q.push_back(s);
        void'(s1q.pop_front());
        m_rgb = s1q[0].rd ? pix_if.i_pixel : '0;
        case (m_phase)
            PH_LOAD: begin
                m_hw = int'(hm_width);  m_hp = int'(hm_porch);
                m_hs = int'(hm_synch);  m_hr = int'(hm_raw);
                m_vh = int'(vm_height); m_vp = int'(vm_porch);
                m_vs = int'(vm_synch);  m_vr = int'(vm_raw);
                if (legal(m_hw, m_hp, m_hs, m_hr) && legal(m_vh, m_vp, m_vs, m_vr)) begin
                    m_phase = PH_RUN;
                    m_t     = 0;
                    m_err   = 1'b0;
                end else begin
                    m_phase = PH_BAD;
                    m_err   = 1'b1;
                end
            end
            PH_RUN: begin
                m_t++;
                if (m_t == m_hr * m_vr) m_phase = PH_LOAD;
            end
            default: m_phase = PH_LOAD;
        endcase
    endtask

    // ---------------- scoreboard / report state ----------------
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            cnt_rd, cnt_nl, cnt_nf, cnt_hs0, cnt_vs0, cnt_abc;
    bit            sb_on    = 1'b0;
    bit            rand_pix = 1'b0;
    bit            rd_last  = 1'b0;
    logic [PW-1:0] pix_val  = 12'hABC;
    logic [31:0]   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        s1_t now_s, old_s;
        now_s = s1q[2];
        old_s = s1q[0];
        check("rd",       32'(pix_if.o_rd),       32'(now_s.rd));
        check("newline",  32'(pix_if.o_newline),  32'(now_s.nl));
        check("newframe", 32'(pix_if.o_newframe), 32'(now_s.nf));
        check("hsync",    32'(hsync),             32'(!old_s.hs));
        check("vsync",    32'(vsync),             32'(!old_s.vs));
        check("rgb",      32'({red, green, blue}), 32'(m_rgb));
        check("mode_err", 32'(mode_err),          32'(m_err));
    endtask

    task automatic clear_counts();
        cnt_rd = 0; cnt_nl = 0; cnt_nf = 0;
        cnt_hs0 = 0; cnt_vs0 = 0; cnt_abc = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        cyc++;
        compare_outputs();
        if (pix_if.o_rd)       cnt_rd++;
        if (pix_if.o_newline)  cnt_nl++;
        if (pix_if.o_newframe) cnt_nf++;
        if (!hsync)            cnt_hs0++;
        if (!vsync)            cnt_vs0++;
        if ({red, green, blue} == 12'hABC) cnt_abc++;
        if (sb_on) begin
            if (pix_if.o_rd) exp_q.push_back(32'(cyc + 2));
            if ({red, green, blue} != '0) begin
                if (exp_q.size() == 0) check("rgb_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                else                   check("rgb_latency", 32'(cyc), exp_q.pop_front());
            end
        end
        // Pixel source: answer a request one clock later, junk otherwise.
        if (rand_pix) pix_val = PW'($urandom);
        pix_if.i_pixel = rd_last ? pix_val : PW'($urandom);
        rd_last = pix_if.o_rd;
    endtask

    task automatic wait_nf(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pix_if.o_newframe && n < limit);
        check("newframe_seen", 32'(pix_if.o_newframe), 32'd1);
    endtask

    task automatic set_mode(input vec_t v);
        hm_width  = 12'(v.hw); hm_porch = 12'(v.hp); hm_synch = 12'(v.hs); hm_raw = 12'(v.hr);
        vm_height = 12'(v.vh); vm_porch = 12'(v.vp); vm_synch = 12'(v.vs); vm_raw = 12'(v.vr);
    endtask

    // ---------------- test ----------------
    initial begin : main
        int n;
        int hr, hw, hp, hs, vr, vh, vp, vs;

        //           hw hp hs hr  vh vp vs vr  rd nl per err
        vecs[0] = '{8, 9, 10, 12, 4, 5, 6, 7, 32, 7, 85, 0};
        vecs[1] = '{6, 7, 8,  9,  3, 4, 5, 5, 18, 5, 46, 0};
        vecs[2] = '{1, 2, 2,  2,  1, 2, 2, 2, 1,  2, 5,  0};
        vecs[3] = '{0, 9, 10, 12, 4, 5, 6, 7, 0,  0, 0,  1};
        vecs[4] = '{8, 3, 10, 12, 4, 5, 6, 7, 0,  0, 0,  1};

        set_mode(vecs[0]);
        pix_if.i_pixel = '0;
        clear_counts();
        model_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_state", 32'(dbg_state), 32'(S_LOAD));
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            set_mode(vecs[i]);
            if (vecs[i].exp_period > 0) begin
                wait_nf(3000, n);
                clear_counts();
                wait_nf(3000, n);
                check("tab_period",   32'(n),                 32'(vecs[i].exp_period));
                check("tab_rd",       32'(cnt_rd),            32'(vecs[i].exp_rd));
                check("tab_nl",       32'(cnt_nl),            32'(vecs[i].exp_nl));
                check("tab_nf_on_nl", 32'(pix_if.o_newline),  32'd1);
                check("tab_err",      32'(mode_err),          32'(vecs[i].exp_err));
            end else begin
                n = 0;
                while (!mode_err && n < 3000) begin
                    tick();
                    n++;
                end
                repeat (4) tick();
                clear_counts();
                repeat (30) tick();
                check("bad_err", 32'(mode_err), 32'(vecs[i].exp_err));
                check("bad_rd",  32'(cnt_rd),   32'd0);
                check("bad_nl",  32'(cnt_nl),   32'd0);
                check("bad_nf",  32'(cnt_nf),   32'd0);
                check("bad_hs",  32'(cnt_hs0),  32'd0);
                check("bad_vs",  32'(cnt_vs0),  32'd0);
            end
        end

        // Illegal porch restored: running again within two clocks.
        set_mode(vecs[0]);
        tick();
        tick();
        check("restore_err", 32'(mode_err),  32'd0);
        check("restore_run", 32'(dbg_state), 32'(S_RUN));

        // Sync widths and pixel return alignment over one full frame.
        wait_nf(3000, n);
        clear_counts();
        pix_val = 12'hABC;
        sb_on   = 1'b1;
        wait_nf(3000, n);
        sb_on   = 1'b0;
        check("hsync_low_clocks", 32'(cnt_hs0), 32'd7);
        check("vsync_low_clocks", 32'(cnt_vs0), 32'd12);
        check("abc_pixels",       32'(cnt_abc), 32'd32);
        check("sb_drained",       32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Width change mid-frame only takes effect on the next frame.
        wait_nf(3000, n);
        clear_counts();
        repeat (30) tick();
        hm_width = 12'd6;
        wait_nf(3000, n);
        check("width_old_frame", 32'(cnt_rd), 32'd32);
        clear_counts();
        wait_nf(3000, n);
        check("width_new_frame", 32'(cnt_rd), 32'd24);
        hm_width = 12'd8;
        wait_nf(3000, n);

        // Reset at hpos=5, vpos=2.
        n = 0;
        while (!(m_phase == PH_RUN && m_t == 2 * 12 + 5) && n < 200) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rd",       32'(pix_if.o_rd),        32'd0);
        check("rst_newline",  32'(pix_if.o_newline),   32'd0);
        check("rst_newframe", 32'(pix_if.o_newframe),  32'd0);
        check("rst_hsync",    32'(hsync),              32'd1);
        check("rst_vsync",    32'(vsync),              32'd1);
        check("rst_rgb",      32'({red, green, blue}), 32'd0);
        check("rst_err",      32'(mode_err),           32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_nf(3000, n);
        check("rst_first_frame", 32'(n), 32'd85);

        // Random modes applied at random times, random pixel data.
        rand_pix = 1'b1;
        for (int k = 0; k < 10; k++) begin
            hr = $urandom_range(40, 4);
            hw = $urandom_range(hr - 1, 1);
            hp = $urandom_range(hr, hw + 1);
            hs = $urandom_range(hr, hp);
            vr = $urandom_range(12, 2);
            vh = $urandom_range(vr - 1, 1);
            vp = $urandom_range(vr, vh + 1);
            vs = $urandom_range(vr, vp);
            if (k % 4 == 3) hp = hw;
            hm_width  = 12'(hw); hm_porch = 12'(hp); hm_synch = 12'(hs); hm_raw = 12'(hr);
            vm_height = 12'(vh); vm_porch = 12'(vp); vm_synch = 12'(vs); vm_raw = 12'(vr);
            repeat ($urandom_range(900, 100)) tick();
        end
        rand_pix = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
